// File: rtl/video_bank_scheduler_if.sv
// Handshake bundle between the mode FSM / SPI writer / VGA reader and the bank scheduler.
// master = environment driving control pulses, slave = the scheduler itself.
interface video_bank_scheduler_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned UR_W  = 8
);
    logic             play_en;
    logic             pause_en;
    logic             frame_start;
    logic             wr_done;
    logic             wr_req;
    logic             wr_bank;
    logic             rd_bank;
    logic             read_bank1;
    logic             read_bank2;
    logic             display_en;
    logic [CNT_W-1:0] frame_count;
    logic [UR_W-1:0]  underrun_cnt;
    logic [3:0]       bank_counter;

    modport master (
        output play_en, pause_en, frame_start, wr_done,
        input  wr_req, wr_bank, rd_bank, read_bank1, read_bank2, display_en,
               frame_count, underrun_cnt, bank_counter
    );

    modport slave (
        input  play_en, pause_en, frame_start, wr_done,
        output wr_req, wr_bank, rd_bank, read_bank1, read_bank2, display_en,
               frame_count, underrun_cnt, bank_counter
    );
endinterface

// File: rtl/video_bank_scheduler.sv
// Ping-pong frame bank scheduler: grants the SPI writer the free bank and swaps the
// VGA read bank on frame boundaries once the current frame has been repeated enough.
module video_bank_scheduler #(
    parameter int unsigned FRAME_REPEAT = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned UR_W         = 8
) (
    input logic                   CLK_40,
    input logic                   reset_n,
    video_bank_scheduler_if.slave bus
);
    localparam int unsigned REP_W = 4;
    localparam int unsigned BC_W  = 4;

    typedef enum logic [2:0] {IDLE, PRIME, WAIT_SYNC, PLAY, PAUSE} state_t;

    state_t             state_q, state_d;
    logic               wr_req_q, wr_req_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               display_en_q, display_en_d;
    logic               read_bank1_q, read_bank1_d;
    logic               read_bank2_q, read_bank2_d;
    logic [1:0]         full_q, full_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [UR_W-1:0]    underrun_q, underrun_d;
    logic [BC_W-1:0]    bank_counter_q, bank_counter_d;

    // State and all outputs registered together
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wr_req_q       <= 1'b0;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            display_en_q   <= 1'b0;
            read_bank1_q   <= 1'b0;
            read_bank2_q   <= 1'b0;
            full_q         <= 2'b00;
            rep_q          <= '0;
            frame_count_q  <= '0;
            underrun_q     <= '0;
            bank_counter_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_req_q       <= wr_req_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            display_en_q   <= display_en_d;
            read_bank1_q   <= read_bank1_d;
            read_bank2_q   <= read_bank2_d;
            full_q         <= full_d;
            rep_q          <= rep_d;
            frame_count_q  <= frame_count_d;
            underrun_q     <= underrun_d;
            bank_counter_q <= bank_counter_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_req_d       = wr_req_q;
        wr_bank_d      = wr_bank_q;
        rd_bank_d      = rd_bank_q;
        display_en_d   = display_en_q;
        full_d         = full_q;
        rep_d          = rep_q;
        frame_count_d  = frame_count_q;
        underrun_d     = underrun_q;
        bank_counter_d = bank_counter_q;

        if (state_q != IDLE && !bus.play_en) begin
            // Stop: statistics hold until the next playback start
            state_d      = IDLE;
            display_en_d = 1'b0;
            wr_req_d     = 1'b0;
            full_d       = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_req_d     = 1'b0;
                    display_en_d = 1'b0;
                    if (bus.play_en) begin
                        state_d        = PRIME;
                        wr_req_d       = 1'b1;
                        wr_bank_d      = 1'b0;
                        rd_bank_d      = 1'b1;
                        full_d         = 2'b00;
                        frame_count_d  = '0;
                        underrun_d     = '0;
                        bank_counter_d = '0;
                    end
                end
                PRIME: begin
                    wr_req_d = 1'b1;
                    if (bus.wr_done) begin
                        full_d[0] = 1'b1;
                        wr_req_d  = 1'b0;
                        state_d   = WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (bus.frame_start) begin
                        state_d       = PLAY;
                        rd_bank_d     = 1'b0;
                        wr_bank_d     = 1'b1;
                        display_en_d  = 1'b1;
                        rep_d         = REP_W'(1);
                        frame_count_d = CNT_W'(1);
                        full_d[1]     = 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.pause_en) begin
                        state_d = PAUSE;
                    end else begin
                        if (bus.wr_done && wr_req_q) full_d[wr_bank_q] = 1'b1;
                        if (bus.frame_start) begin
                            if (rep_q < REP_W'(FRAME_REPEAT)) begin
                                rep_d = rep_q + REP_W'(1);
                            end else if (full_d[wr_bank_q]) begin
                                rd_bank_d         = wr_bank_q;
                                wr_bank_d         = rd_bank_q;
                                full_d[rd_bank_q] = 1'b0;
                                rep_d             = REP_W'(1);
                                frame_count_d     = frame_count_q + CNT_W'(1);
                                bank_counter_d    = bank_counter_q + BC_W'(1);
                            end else if (underrun_q != {UR_W{1'b1}}) begin
                                underrun_d = underrun_q + UR_W'(1);
                            end
                        end
                    end
                end
                PAUSE: begin
                    // Writer keeps prefetching; frame boundaries are not counted
                    if (bus.wr_done && wr_req_q) full_d[wr_bank_q] = 1'b1;
                    if (!bus.pause_en) state_d = PLAY;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == PLAY || state_d == PAUSE) wr_req_d = ~full_d[wr_bank_d];

        read_bank1_d = display_en_d & ~rd_bank_d;
        read_bank2_d = display_en_d & rd_bank_d;
    end

    assign bus.wr_req       = wr_req_q;
    assign bus.wr_bank      = wr_bank_q;
    assign bus.rd_bank      = rd_bank_q;
    assign bus.display_en   = display_en_q;
    assign bus.read_bank1   = read_bank1_q;
    assign bus.read_bank2   = read_bank2_q;
    assign bus.frame_count  = frame_count_q;
    assign bus.underrun_cnt = underrun_q;
    assign bus.bank_counter = bank_counter_q;
endmodule

// File: tb/tb_video_bank_scheduler.sv
// Directed bench for video_bank_scheduler with FRAME_REPEAT=2 and hand-computed expectations.
module tb_video_bank_scheduler;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    video_bank_scheduler_if #(.CNT_W(16), .UR_W(8)) bus ();

    video_bank_scheduler #(.FRAME_REPEAT(2), .CNT_W(16), .UR_W(8)) dut (
        .CLK_40  (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse_wd();
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n         = 1'b0;
        bus.play_en     = 1'b0;
        bus.pause_en    = 1'b0;
        bus.frame_start = 1'b0;
        bus.wr_done     = 1'b0;
        step();
        step();
        check("rst_display_en", 32'(bus.display_en), 0);
        check("rst_wr_req", 32'(bus.wr_req), 0);
        check("rst_rd_bank", 32'(bus.rd_bank), 0);
        check("rst_frame_count", 32'(bus.frame_count), 0);

        // Prime the first bank
        reset_n     = 1'b1;
        bus.play_en = 1'b1;
        step();
        check("prime_wr_req", 32'(bus.wr_req), 1);
        check("prime_wr_bank", 32'(bus.wr_bank), 0);
        check("prime_rd_bank", 32'(bus.rd_bank), 1);
        pulse_fs();
        check("prime_fs_ignored", 32'(bus.display_en), 0);
        pulse_wd();
        check("wait_wr_req", 32'(bus.wr_req), 0);
        step();
        pulse_fs();
        check("play_rd_bank", 32'(bus.rd_bank), 0);
        check("play_wr_bank", 32'(bus.wr_bank), 1);
        check("play_read_bank1", 32'(bus.read_bank1), 1);
        check("play_read_bank2", 32'(bus.read_bank2), 0);
        check("play_frame_count", 32'(bus.frame_count), 1);
        check("play_wr_req", 32'(bus.wr_req), 1);

        // Steady state: one written frame per two frame boundaries
        for (int k = 1; k <= 8; k++) begin
            pulse_wd();
            check("steady_wr_req_drop", 32'(bus.wr_req), 0);
            step();
            pulse_fs();
            check("steady_hold_rd", 32'(bus.rd_bank), 32'((k - 1) % 2));
            pulse_fs();
            check("steady_swap_rd", 32'(bus.rd_bank), 32'(k % 2));
        end
        check("steady_bank_counter", 32'(bus.bank_counter), 8);
        check("steady_frame_count", 32'(bus.frame_count), 9);
        check("steady_underrun", 32'(bus.underrun_cnt), 0);

        // Underrun: three due boundaries without a ready frame
        pulse_fs();
        for (int i = 0; i < 3; i++) pulse_fs();
        check("ur_rd_bank", 32'(bus.rd_bank), 0);
        check("ur_count", 32'(bus.underrun_cnt), 3);
        check("ur_frame_count", 32'(bus.frame_count), 9);
        pulse_wd();
        pulse_fs();
        check("ur_recover_rd", 32'(bus.rd_bank), 1);
        check("ur_recover_fc", 32'(bus.frame_count), 10);
        check("ur_recover_bc", 32'(bus.bank_counter), 9);

        // wr_done coincident with the due frame_start
        pulse_fs();
        bus.wr_done     = 1'b1;
        bus.frame_start = 1'b1;
        step();
        bus.wr_done     = 1'b0;
        bus.frame_start = 1'b0;
        check("simul_rd_bank", 32'(bus.rd_bank), 0);
        check("simul_frame_count", 32'(bus.frame_count), 11);
        check("simul_underrun", 32'(bus.underrun_cnt), 3);

        // Pause across five frame boundaries with a prefetch
        bus.pause_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            pulse_fs();
            check("pause_rd_bank", 32'(bus.rd_bank), 0);
            check("pause_read_bank1", 32'(bus.read_bank1), 1);
        end
        check("pause_frame_count", 32'(bus.frame_count), 11);
        check("pause_underrun", 32'(bus.underrun_cnt), 3);
        check("pause_display_en", 32'(bus.display_en), 1);
        check("pause_wr_req_before", 32'(bus.wr_req), 1);
        pulse_wd();
        check("pause_wr_req_drop", 32'(bus.wr_req), 0);
        bus.pause_en = 1'b0;
        step();
        pulse_fs();
        check("resume_rep_kept", 32'(bus.frame_count), 11);
        pulse_fs();
        check("resume_swap_rd", 32'(bus.rd_bank), 1);
        check("resume_swap_fc", 32'(bus.frame_count), 12);

        // Underrun saturation
        pulse_fs();
        for (int i = 0; i < 300; i++) pulse_fs();
        check("sat_underrun", 32'(bus.underrun_cnt), 255);
        check("sat_rd_bank", 32'(bus.rd_bank), 1);

        // Stop then restart
        bus.play_en = 1'b0;
        step();
        check("stop_display_en", 32'(bus.display_en), 0);
        check("stop_wr_req", 32'(bus.wr_req), 0);
        check("stop_read_bank2", 32'(bus.read_bank2), 0);
        check("stop_underrun_hold", 32'(bus.underrun_cnt), 255);
        check("stop_fc_hold", 32'(bus.frame_count), 12);
        bus.play_en = 1'b1;
        step();
        check("restart_underrun", 32'(bus.underrun_cnt), 0);
        check("restart_fc", 32'(bus.frame_count), 0);
        check("restart_bc", 32'(bus.bank_counter), 0);
        check("restart_wr_req", 32'(bus.wr_req), 1);

        // Asynchronous reset in the middle of playback
        pulse_wd();
        step();
        pulse_fs();
        check("pre_reset_display", 32'(bus.display_en), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_display_en", 32'(bus.display_en), 0);
        check("async_read_bank1", 32'(bus.read_bank1), 0);
        check("async_wr_bank", 32'(bus.wr_bank), 0);
        check("async_frame_count", 32'(bus.frame_count), 0);
        step();
        reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/video_bank_scheduler.md
Name: video_bank_scheduler

Overview:
- Sequences the two ping-pong video frame banks between the SPI frame writer and the VGA reader.
- Grants the writer the free bank and selects which bank the VGA side reads.
- Swaps banks only on a VGA frame boundary, after each source frame has been shown FRAME_REPEAT times and the other bank holds a complete frame.
- Sits between the mode FSM (play/pause) and video_top. It drives read_bank1/read_bank2 and the display enable.

Parameters:
FRAME_REPEAT, 2, VGA frames each source frame is displayed (60 Hz VGA / 30 fps source); legal range 1..15
CNT_W, 16, width of frame_count
UR_W, 8, width of underrun_cnt

Ports:
CLK_40  input  1  system clock, 40 MHz
reset_n  input  1  asynchronous active-low reset
play_en  input  1  level from mode FSM; 1 = video playback active
pause_en  input  1  level; freeze the displayed frame
frame_start  input  1  one-cycle pulse at start of VGA vertical blank
wr_done  input  1  one-cycle pulse: writer finished a full frame into wr_bank
wr_req  output  1  level: writer may fill wr_bank
wr_bank  output  1  bank index the writer targets (0/1)
rd_bank  output  1  bank index the VGA side reads
read_bank1  output  1  display_en & (rd_bank==0)
read_bank2  output  1  display_en & (rd_bank==1)
display_en  output  1  VGA sync/pixel output enable
frame_count  output  CNT_W  source frames presented since playback start, wraps
underrun_cnt  output  UR_W  frame boundaries where a swap was due but no frame was ready; saturating
bank_counter  output  4  swap count modulo 16, for LEDs

Behaviour:
- All outputs registered. reset_n low immediately (asynchronously) forces:
  - state IDLE; all outputs 0.
  - internal full[1:0]=0 and rep_cnt=0.
- States: IDLE, PRIME, WAIT_SYNC, PLAY, PAUSE.
- IDLE:
  - wr_req=0, display_en=0.
  - play_en=1 -> PRIME next cycle. On that transition: wr_bank=0, rd_bank=1, full=0, frame_count=0, underrun_cnt=0, bank_counter=0.
- PRIME:
  - wr_req=1.
  - wr_done -> full[0]=1, wr_req=0 next cycle, go to WAIT_SYNC.
  - frame_start is ignored.
- WAIT_SYNC:
  - At frame_start: rd_bank=0, wr_bank=1, display_en=1, rep_cnt=1, frame_count=1, full[1]=0, go to PLAY.
- PLAY:
  - wr_req = ~full[wr_bank], registered, so it deasserts the cycle after the accepted wr_done.
  - wr_done with wr_req=1 sets full[wr_bank]. wr_done with wr_req=0 is ignored.
  - frame_start with rep_cnt<FRAME_REPEAT: rep_cnt++.
  - frame_start with rep_cnt==FRAME_REPEAT and (full[wr_bank] or wr_done in the same cycle): swap.
    - rd_bank<=wr_bank, wr_bank<=rd_bank.
    - full[old rd_bank]=0, full[new rd_bank] stays 1.
    - rep_cnt=1, frame_count++ (wrapping), bank_counter++ (wrapping).
    - New rd_bank is visible the cycle after frame_start.
  - frame_start with rep_cnt==FRAME_REPEAT and no frame ready: underrun.
    - Banks unchanged; rep_cnt holds at FRAME_REPEAT.
    - underrun_cnt++, saturating at all-ones.
    - The swap is retried at each following frame_start.
- PAUSE:
  - Entered from PLAY when pause_en=1. Exit to PLAY when pause_en=0.
  - display_en stays 1, rd_bank held.
  - frame_start does not advance rep_cnt and does not count underruns.
  - The writer continues prefetch (wr_req rule as in PLAY).
  - rep_cnt is preserved across the pause.
- play_en=0 in any non-IDLE state -> IDLE next cycle:
  - display_en=0, wr_req=0, full=0.
  - frame_count, underrun_cnt and bank_counter hold their values until the next IDLE->PRIME.
- Priority within a cycle: play_en=0 > pause_en > frame_start/wr_done.
- FRAME_REPEAT=1: every frame_start with a ready bank swaps.

Test Plan:
- Reset and prime: reset_n low mid-PLAY -> all outputs 0 the same cycle. Release, play_en=1 -> PRIME with wr_req=1, wr_bank=0. wr_done -> WAIT_SYNC. frame_start -> rd_bank=0, wr_bank=1, read_bank1=1, frame_count=1.
- Steady state (FRAME_REPEAT=2): wr_done once per 2 frame_starts -> swap on every 2nd frame_start; rd_bank toggles 0,1,0. After 8 swaps bank_counter=8 and frame_count=9; underrun_cnt=0.
- Underrun: withhold wr_done for 3 due frame boundaries -> rd_bank unchanged, underrun_cnt=3. Then wr_done -> swap at the next frame_start.
- Simultaneous events: wr_done and the due frame_start in the same cycle -> swap occurs; no underrun counted.
- Pause: pause_en asserted for 5 frame_starts -> rd_bank, rep_cnt and frame_count constant, underrun_cnt constant, read_bank stays asserted. Prefetch wr_done sets full with wr_req dropping.
- Stop and saturation: force 300 underruns -> underrun_cnt=255. play_en=0 -> display_en=0, wr_req=0 next cycle. play_en=1 -> underrun_cnt=0 on entering PRIME.
